// File: rtl/iobus_initiator.sv
// iobus_initiator: single-outstanding IO bus master driving MCS-style IO bus cycles from a request port
// Ports:
//   Clk, Reset_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                  request handshake (req_ready high only in IDLE)
//   req_we, req_addr, req_be, req_wdata  request fields, registered on accept
//   rsp_valid/rsp_ready                  response handshake, response held until consumed
//   rsp_rdata, rsp_err                   read data (0 for writes/errors), timeout flag
//   IO_Addr/Read/Write_Strobe            one-cycle strobes at start of bus cycle
//   IO_Address, IO_Byte_Enable,          bus fields, held from strobe until the response
//   IO_Write_Data                        is consumed
//   IO_Read_Data, IO_Ready               responder data and completion pulse
module iobus_initiator #(
    parameter logic [15:0] P_TIMEOUT = 16'd255,
    parameter int          P_TO_W    = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        IO_Addr_Strobe,
    output logic        IO_Read_Strobe,
    output logic        IO_Write_Strobe,
    output logic [31:0] IO_Address,
    output logic [3:0]  IO_Byte_Enable,
    output logic [31:0] IO_Write_Data,
    input  logic [31:0] IO_Read_Data,
    input  logic        IO_Ready
);
    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;
    state_t            state;
    logic              we_q;
    logic [P_TO_W-1:0] to_cnt;
    logic              timeout;
    // Gated with Reset_n so every output reads 0 while reset is held.
    assign req_ready = Reset_n && state == S_IDLE;
    // to_cnt counts completed WAIT cycles, so this fires on the P_TIMEOUT-th WAIT cycle.
    assign timeout = (P_TIMEOUT != 16'd0) && (to_cnt == P_TO_W'(P_TIMEOUT - 16'd1));
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= S_IDLE;
            we_q            <= 1'b0;
            to_cnt          <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            IO_Addr_Strobe  <= 1'b0;
            IO_Read_Strobe  <= 1'b0;
            IO_Write_Strobe <= 1'b0;
            IO_Address      <= '0;
            IO_Byte_Enable  <= '0;
            IO_Write_Data   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    we_q            <= req_we;
                    IO_Address      <= req_addr;
                    IO_Byte_Enable  <= req_be;
                    IO_Write_Data   <= req_we ? req_wdata : '0;
                    IO_Addr_Strobe  <= 1'b1;
                    IO_Read_Strobe  <= !req_we;
                    IO_Write_Strobe <= req_we;
                    state           <= S_STROBE;
                end
                S_STROBE: begin
                    IO_Addr_Strobe  <= 1'b0;
                    IO_Read_Strobe  <= 1'b0;
                    IO_Write_Strobe <= 1'b0;
                    to_cnt          <= '0;
                    state           <= S_WAIT;
                end
                S_WAIT: if (IO_Ready || timeout) begin
                    // IO_Ready takes priority over a timeout in the same cycle.
                    rsp_rdata <= (IO_Ready && !we_q) ? IO_Read_Data : '0;
                    rsp_err   <= !IO_Ready;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid      <= 1'b0;
                    rsp_rdata      <= '0;
                    rsp_err        <= 1'b0;
                    we_q           <= 1'b0;
                    IO_Address     <= '0;
                    IO_Byte_Enable <= '0;
                    IO_Write_Data  <= '0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iobus_initiator.sv
// tb_iobus_initiator: randomized self-checking bench for iobus_initiator against a latency/response model
module tb_iobus_initiator;
    localparam int TO = 8;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, IO_Ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, IO_Read_Data = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err, IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe;
    logic [31:0] rsp_rdata, IO_Address, IO_Write_Data;
    logic [3:0]  IO_Byte_Enable;
    int checks = 0, errors = 0;

    iobus_initiator #(.P_TIMEOUT(16'(TO)), .P_TO_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Read_Strobe(IO_Read_Strobe),
        .IO_Write_Strobe(IO_Write_Strobe), .IO_Address(IO_Address),
        .IO_Byte_Enable(IO_Byte_Enable), .IO_Write_Data(IO_Write_Data),
        .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready)
    );

    always #5 Clk = ~Clk;

    function automatic logic [137:0] all_outs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_err, IO_Addr_Strobe, IO_Read_Strobe,
                IO_Write_Strobe, IO_Address, IO_Byte_Enable, IO_Write_Data};
    endfunction

    // One full transaction. k = WAIT cycle (1-based) in which the responder pulses IO_Ready,
    // 0 = never. hold = cycles rsp_ready is kept low once the response appears.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] rd, input int k,
                          input bit rdy_in_strobe, input int hold, input string tag);
        int c, lat, n_as, n_rs, n_ws, exp_lat;
        bit held, stable;
        logic exp_err;
        logic [31:0] exp_rd;
        if (k >= 1 && k <= TO) begin
            exp_err = 1'b0; exp_rd = we ? 32'd0 : rd; exp_lat = k + 2;
        end else begin
            exp_err = 1'b1; exp_rd = 32'd0; exp_lat = TO + 2;
        end
        @(negedge Clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got %b want 1", tag, req_ready); end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        @(negedge Clk);
        req_valid = 1'b0; req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom; req_we = ~we;
        c = 1; lat = 0; n_as = 0; n_rs = 0; n_ws = 0; held = 1'b1;
        while (c < 300) begin
            if (rsp_valid === 1'b1) begin lat = c; break; end
            n_as += int'(IO_Addr_Strobe); n_rs += int'(IO_Read_Strobe); n_ws += int'(IO_Write_Strobe);
            if (IO_Address !== addr || IO_Byte_Enable !== be || IO_Write_Data !== (we ? wdata : 32'd0) || req_ready !== 1'b0)
                held = 1'b0;
            IO_Ready = (c == 1) ? rdy_in_strobe : (c - 1 == k);
            IO_Read_Data = rd;
            @(negedge Clk);
            c++;
        end
        IO_Ready = 1'b0; IO_Read_Data = $urandom;
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat); end
        checks++;
        if (n_as != 1 || n_rs != int'(!we) || n_ws != int'(we))
            begin errors++; $display("FAIL %s strobes got as=%0d rs=%0d ws=%0d want 1/%0d/%0d", tag, n_as, n_rs, n_ws, !we, we); end
        checks++;
        if (!held) begin errors++; $display("FAIL %s fields_held got 0 want 1", tag); end
        checks++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_err)
            begin errors++; $display("FAIL %s rsp got rdata=%h err=%b want rdata=%h err=%b", tag, rsp_rdata, rsp_err, exp_rd, exp_err); end
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err || req_ready !== 1'b0 ||
                IO_Address !== addr)
                stable = 1'b0;
            IO_Ready = (h == 1);
            @(negedge Clk);
        end
        IO_Ready = 1'b0;
        if (hold > 0) begin
            checks++;
            if (!stable) begin errors++; $display("FAIL %s rsp_stable got 0 want 1", tag); end
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || IO_Address !== 32'd0 || IO_Byte_Enable !== 4'd0 || IO_Write_Data !== 32'd0)
            begin errors++; $display("FAIL %s idle_after got valid=%b ready=%b addr=%h want 0 1 0", tag, rsp_valid, req_ready, IO_Address); end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", all_outs()); end
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_release got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_write();
        do_txn(1'b1, 32'hC000_0000, 4'hF, 32'hA5A5_0001, 32'hDEAD_BEEF, 1, 1'b0, 0, "write");
    endtask

    task automatic test_read();
        do_txn(1'b0, 32'hC000_1004, 4'hF, 32'h0, 32'h1234_5678, 6, 1'b0, 0, "read");
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 32'hC000_2000, 4'h3, 32'h0, 32'h5555_AAAA, 0, 1'b0, 4, "timeout");
        do_txn(1'b0, 32'hC000_2004, 4'hC, 32'h0, 32'h0BAD_F00D, 2, 1'b0, 0, "after_timeout");
    endtask

    task automatic test_ignore_ready();
        @(negedge Clk);
        IO_Ready = 1'b1; IO_Read_Data = 32'hFFFF_FFFF;
        @(negedge Clk);
        IO_Ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || IO_Addr_Strobe !== 1'b0)
            begin errors++; $display("FAIL idle_ready got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        do_txn(1'b0, 32'h0000_0010, 4'h1, 32'h0, 32'hCAFE_0001, 3, 1'b1, 0, "strobe_ready");
        do_txn(1'b1, 32'h0000_0014, 4'h2, 32'h7777_0000, 32'hCAFE_0002, TO, 1'b0, 0, "ready_on_timeout");
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 32'hC000_3000, 4'hF, 32'h0, 32'h8765_4321, 2, 1'b0, 10, "backpressure");
    endtask

    task automatic test_reset_mid();
        bit quiet;
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC000_4000; req_be = 4'hF; req_wdata = 32'h1111_2222;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk); @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL mid_reset_outs got %h want 0", all_outs()); end
        @(negedge Clk);
        Reset_n = 1'b1; IO_Ready = 1'b1; IO_Read_Data = 32'h3333_4444;
        @(negedge Clk);
        IO_Ready = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || IO_Addr_Strobe !== 1'b0 || IO_Address !== 32'd0) quiet = 1'b0;
            @(negedge Clk);
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL mid_reset_quiet got 0 want 1"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            do_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, TO + 3)), 1'($urandom), int'($urandom_range(0, 3)), "random");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ignore_ready();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            do_txn(1'(i & 1), 32'h1000_0000 + 32'(4 * i), 4'hF, 32'(i) * 32'h0101_0101, 32'hABCD_0000 + 32'(i), 1, 1'b0, 0, "back_to_back");
    endtask
endmodule
